sha3_sponge_ctrl: RTL
=====================

// Module: sha3_sponge_ctrl
// PURPOSE
//  Sponge-level sequencer that drives the 24-round constant counter and round datapath of the SHA3 core.
//  - Absorb: accepts padded rate lanes over a valid/ready stream and issues lane-XOR strobes.
//  - Permute: restarts the constant counter, enables rounds, and consumes the counter's done flag.
//  - Squeeze: issues digest lanes over a valid/ready stream, then clears state for the next message.
// PARAMETERS
//  RATE_LANES  17  64-bit lanes per rate block (SHA3-256 = 17)
//  OUT_LANES   4   64-bit lanes squeezed per digest (SHA3-256 = 4)
//  ROUNDS      24  expected ROUND_EN cycles per permutation (watchdog)
// PORTS
//  CLK           in   1  single clock, rising edge
//  A_RST_N       in   1  asynchronous, active-low reset
//  IN_VALID      in   1  rate lane available (data goes straight to datapath)
//  IN_READY      out  1  controller accepts lane this cycle
//  IN_LAST       in   1  lane is final lane of final block of message
//  ABSORB_EN     out  1  XOR current input lane into state[LANE_IDX]
//  LANE_IDX      out  5  absorb lane index, 0..RATE_LANES-1
//  CNT_RESET     out  1  to constant counter COUNTER_RESET
//  PERM_CE       out  1  to constant counter CE
//  ROUND_EN      out  1  round datapath applies one round this cycle
//  PERM_DONE     in   1  from constant counter WAIT_FOR_NEW_MESSAGE
//  OUT_VALID     out  1  digest lane OUT_LANE_IDX valid on datapath output
//  OUT_READY     in   1  sink accepts digest lane
//  OUT_LANE_IDX  out  3  squeeze lane index, 0..OUT_LANES-1
//  OUT_LAST      out  1  final digest lane
//  STATE_CLEAR   out  1  zero the 1600-bit state this cycle
//  BUSY          out  1  state != ABSORB or lane counter != 0
//  ERR           out  1  sticky protocol/watchdog error, cleared only by reset
// BEHAVIOUR
//  - Reset (A_RST_N=0, immediate):
//    - State=ABSORB; lane, out, and round counters=0; last_blk=0; ERR=0.
//    - All registered outputs 0. IN_READY=1 because it decodes comb from ABSORB.
//  - FSM: ABSORB -> PSTART -> PERM -> (SQUEEZE -> CLEAR ->) ABSORB.
//  - ABSORB:
//    - IN_READY=1; ABSORB_EN=IN_VALID&IN_READY (comb); LANE_IDX=lane counter.
//    - Handshake advances the lane counter.
//    - Handshake at lane RATE_LANES-1: lane counter->0, last_blk<=IN_LAST, go PSTART.
//    - IN_LAST=1 at any other lane: ERR<=1, flag ignored, absorb continues.
//  - PSTART (1 cycle): CNT_RESET=1, PERM_CE=1, ROUND_EN=0. Counter goes to 0, PERM_DONE goes to 0. Round counter->0.
//  - PERM:
//    - PERM_CE=ROUND_EN=~PERM_DONE (comb); round counter increments on ROUND_EN.
//    - Exactly ROUNDS cycles of ROUND_EN; PERM_DONE seen on the cycle after the 24th round.
//    - Exit on PERM_DONE=1: last_blk ? SQUEEZE : ABSORB.
//    - Watchdog: round counter==ROUNDS and PERM_DONE=0 -> ERR<=1, forced exit as if done.
//    - PERM_DONE=1 with round counter<ROUNDS -> ERR<=1, exit anyway.
//  - PERM_DONE is ignored outside PERM, so a stale 1 from the previous message is harmless.
//  - SQUEEZE:
//    - OUT_VALID=1, OUT_LANE_IDX=out counter, OUT_LAST=(out counter==OUT_LANES-1).
//    - OUT_VALID is held until OUT_READY; the index is stable while stalled.
//    - Last handshake: out counter->0, go CLEAR.
//  - CLEAR (1 cycle): STATE_CLEAR=1, IN_READY=0, next ABSORB.
//  - Latency: last-lane handshake at cycle t -> PSTART t+1, ROUND_EN t+2..t+25, PERM_DONE seen t+26.
//    First OUT_VALID (or IN_READY for the next block) at t+27.
//  - Throughput: one lane/cycle with IN_VALID held high. IN_READY=0 in PSTART, PERM, SQUEEZE, CLEAR.
//  - Counter widths: lane 5b, out 3b, round 5b. No wrap beyond parameter limits.
//  - Reset mid-permutation or mid-squeeze returns to ABSORB lane 0. No STATE_CLEAR pulse is issued; the datapath has its own reset.
// TESTING
//  - Single block: 17 lanes, IN_LAST on lane 16 -> one CNT_RESET; ROUND_EN high exactly 24 cycles;
//    OUT_VALID at t+27; 4 lanes idx 0..3, OUT_LAST on 3; STATE_CLEAR one cycle; ERR=0.
//  - Two blocks (34 lanes, IN_LAST on lane 33) -> two PSTART pulses, IN_READY=0 for 26 cycles between blocks, one squeeze.
//  - Backpressure: OUT_READY low for 5 cycles on lane 2 -> OUT_VALID and OUT_LANE_IDX=2 held; no skipped or repeated index.
//  - IN_VALID gaps and IN_LAST on lane 5 -> ERR=1 sticky, absorb still runs to lane 16, message not treated as last.
//  - Counter model that never raises PERM_DONE -> ERR=1 after 24 ROUND_EN cycles, forced exit.
//    Early PERM_DONE at round 10 -> ERR=1, exit.
//  - A_RST_N pulsed low during PERM round 12 -> all outputs 0, IN_READY=1, LANE_IDX=0; next message completes normally.

Source files
------------

// File: rtl/sha3_sponge_ctrl.sv
// Sponge-level sequencer for the SHA3 core: absorb rate lanes, run one
// permutation per block through the round-constant counter, squeeze the digest.
// Ports:
//   CLK, A_RST_N               clock, async active-low reset
//   IN_VALID/IN_READY/IN_LAST  rate-lane input stream
//   ABSORB_EN, LANE_IDX        lane-XOR strobe and target lane
//   CNT_RESET, PERM_CE         constant counter control
//   ROUND_EN, PERM_DONE        round strobe, counter done flag
//   OUT_VALID/OUT_READY        digest-lane output stream
//   OUT_LANE_IDX, OUT_LAST     digest lane index, final-lane flag
//   STATE_CLEAR                zero the sponge state
//   BUSY, ERR                  activity flag, sticky protocol/watchdog error
module sha3_sponge_ctrl #(
  parameter int unsigned RATE_LANES = 17,
  parameter int unsigned OUT_LANES  = 4,
  parameter int unsigned ROUNDS     = 24
) (
  input  logic       CLK,
  input  logic       A_RST_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       IN_LAST,
  output logic       ABSORB_EN,
  output logic [4:0] LANE_IDX,
  output logic       CNT_RESET,
  output logic       PERM_CE,
  output logic       ROUND_EN,
  input  logic       PERM_DONE,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [2:0] OUT_LANE_IDX,
  output logic       OUT_LAST,
  output logic       STATE_CLEAR,
  output logic       BUSY,
  output logic       ERR
);

  localparam int unsigned LANE_W = 5;
  localparam int unsigned OUT_W  = 3;
  localparam int unsigned RND_W  = 5;

  typedef enum logic [2:0] {
    ST_ABSORB,
    ST_PSTART,
    ST_PERM,
    ST_SQUEEZE,
    ST_CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [LANE_W-1:0] lane_cnt, lane_nxt;
  logic [OUT_W-1:0]  out_cnt, out_nxt;
  logic [RND_W-1:0]  round_cnt, round_nxt;
  logic              last_blk, last_nxt;
  logic              err_q, err_nxt;

  // State and counter registers
  always_ff @(posedge CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state     <= ST_ABSORB;
      lane_cnt  <= '0;
      out_cnt   <= '0;
      round_cnt <= '0;
      last_blk  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      lane_cnt  <= lane_nxt;
      out_cnt   <= out_nxt;
      round_cnt <= round_nxt;
      last_blk  <= last_nxt;
      err_q     <= err_nxt;
    end
  end

  // Next-state, counter updates and output decode
  always_comb begin
    state_nxt    = state;
    lane_nxt     = lane_cnt;
    out_nxt      = out_cnt;
    round_nxt    = round_cnt;
    last_nxt     = last_blk;
    err_nxt      = err_q;
    IN_READY     = 1'b0;
    ABSORB_EN    = 1'b0;
    CNT_RESET    = 1'b0;
    PERM_CE      = 1'b0;
    ROUND_EN     = 1'b0;
    OUT_VALID    = 1'b0;
    OUT_LAST     = 1'b0;
    STATE_CLEAR  = 1'b0;
    LANE_IDX     = lane_cnt;
    OUT_LANE_IDX = out_cnt;

    case (state)
      ST_ABSORB: begin
        IN_READY  = 1'b1;
        ABSORB_EN = IN_VALID;
        if (IN_VALID) begin
          if (lane_cnt == LANE_W'(RATE_LANES - 1)) begin
            lane_nxt  = '0;
            last_nxt  = IN_LAST;
            state_nxt = ST_PSTART;
          end else begin
            lane_nxt = lane_cnt + LANE_W'(1);
            // IN_LAST before the final rate lane is a protocol error and is dropped
            if (IN_LAST) err_nxt = 1'b1;
          end
        end
      end

      ST_PSTART: begin
        CNT_RESET = 1'b1;
        PERM_CE   = 1'b1;
        round_nxt = '0;
        state_nxt = ST_PERM;
      end

      ST_PERM: begin
        if (PERM_DONE) begin
          // Early done is flagged but still honoured
          if (round_cnt != RND_W'(ROUNDS)) err_nxt = 1'b1;
          state_nxt = last_blk ? ST_SQUEEZE : ST_ABSORB;
        end else if (round_cnt == RND_W'(ROUNDS)) begin
          // Watchdog: counter never signalled done; no extra round is issued
          err_nxt   = 1'b1;
          state_nxt = last_blk ? ST_SQUEEZE : ST_ABSORB;
        end else begin
          ROUND_EN  = 1'b1;
          PERM_CE   = 1'b1;
          round_nxt = round_cnt + RND_W'(1);
        end
      end

      ST_SQUEEZE: begin
        OUT_VALID = 1'b1;
        OUT_LAST  = (out_cnt == OUT_W'(OUT_LANES - 1));
        if (OUT_READY) begin
          if (out_cnt == OUT_W'(OUT_LANES - 1)) begin
            out_nxt   = '0;
            state_nxt = ST_CLEAR;
          end else begin
            out_nxt = out_cnt + OUT_W'(1);
          end
        end
      end

      ST_CLEAR: begin
        STATE_CLEAR = 1'b1;
        last_nxt    = 1'b0;
        state_nxt   = ST_ABSORB;
      end

      default: state_nxt = ST_ABSORB;
    endcase
  end

  assign BUSY = (state != ST_ABSORB) || (lane_cnt != '0);
  assign ERR  = err_q;

endmodule
